jtframe_rom_responder: RTL and testbench

ROM-side responder for a CPU subsystem that stalls on `rom_cs`/`rom_ok`. It serves byte fetches from a 16-bit SDRAM ROM port through a two-entry word cache. On a hit, `rom_ok` rises in the same cycle; on a miss, it issues one SDRAM word request and raises `rom_ok` when the data lands. It sits between the CPU address decoder and the SDRAM request slot. Its `rom_ok` drives the CPU wait/gate logic that freezes the CPU clock enables.

---
 rtl/jtframe_rom_responder.sv | 148 ++++++++++++++
 tb/tb_jtframe_rom_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_rom_responder.sv
// ROM responder: serves CPU byte fetches from a 16-bit SDRAM port through a
// two-entry word cache. A hit answers combinationally in the same cycle.
// A miss issues a single SDRAM word request and fills the cache when the
// data arrives. Requests that are in flight always run to completion.
module jtframe_rom_responder #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          downloading,
  input  logic [AW-1:0] cpu_addr,
  input  logic          rom_cs,
  output logic          rom_ok,
  output logic [7:0]    rom_data,
  output logic          sdram_req,
  output logic [AW-2:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [15:0]   sdram_din
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               req_q, req_d;
  logic [AW-2:0]      addr_q, addr_d;
  logic [1:0]         valid_q, valid_d;
  logic [1:0][AW-2:0] tag_q, tag_d;
  logic [1:0][15:0]   data_q, data_d;
  logic               lru_q, lru_d;

  logic [AW-2:0]      word_w;
  logic [1:0]         match;
  logic               hit_any;
  logic               hit;
  logic               hit_idx;
  logic [15:0]        hit_word;
  logic               fill_evt;

  assign word_w = cpu_addr[AW-1:1];

  // Tag compare against both entries; the byte is picked out of the hit word.
  // Only one entry can ever hold a given word, so entry 0 taking priority
  // is never observable.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      match[i] = valid_q[i] && (tag_q[i] == word_w);
    end
    hit_any  = |match;
    hit      = rom_cs && !downloading && hit_any;
    hit_idx  = !match[0];
    hit_word = data_q[hit_idx];
    rom_ok   = hit;
    rom_data = 8'h00;
    if (hit) begin
      rom_data = cpu_addr[0] ? hit_word[15:8] : hit_word[7:0];
    end
  end

  // Request FSM: one outstanding SDRAM word request, never cancelled once
  // issued. A fill event is the cycle the requested word is on sdram_din.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    fill_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rom_cs && !downloading && !hit_any) begin
          addr_d  = word_w;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          if (data_rdy) begin
            fill_evt = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (data_rdy) begin
          fill_evt = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Cache update: hits point lru at the other entry, a fill overrides that
  // and replaces the lru entry. A download wipes every valid bit, including
  // one a fill would have set in the same cycle.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    lru_d   = lru_q;
    if (hit) begin
      lru_d = ~hit_idx;
    end
    if (fill_evt && !downloading) begin
      valid_d[lru_q] = 1'b1;
      tag_d[lru_q]   = addr_q;
      data_d[lru_q]  = sdram_din;
      lru_d          = ~lru_q;
    end
    if (downloading) begin
      valid_d = 2'b00;
    end
  end

  // State registers with synchronous active-low reset; reset abandons any
  // request in flight, so a late data_rdy lands in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 2'b00;
      tag_q   <= '0;
      data_q  <= '0;
      lru_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      lru_q   <= lru_d;
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jtframe_rom_responder.sv
// Bench for jtframe_rom_responder: directed scenarios plus a random fetch
// stream. Expectations come from a ROM image and a true-LRU list of the two
// most recently used words; a monitor pops them from a scoreboard queue
// whenever rom_ok is seen.
module tb_jtframe_rom_responder;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rstn, downloading, rom_cs, sdram_ack, data_rdy;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   sdram_din;
  logic          rom_ok, sdram_req;
  logic [7:0]    rom_data;
  logic [AW-2:0] sdram_addr;

  jtframe_rom_responder #(.AW(AW)) dut (
    .clk(clk), .rstn(rstn), .downloading(downloading), .cpu_addr(cpu_addr),
    .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .sdram_din(sdram_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ROM image served by the SDRAM model
  logic [15:0] mem [0:(1<<(AW-1))-1];

  function automatic logic [7:0] exp_byte(input logic [AW-1:0] a);
    logic [15:0] w;
    w = mem[a[AW-1:1]];
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // Reference cache: list of cached words, front = least recently used
  logic [AW-2:0] mc[$];

  function automatic bit model_access(input logic [AW-2:0] w);
    for (int i = 0; i < mc.size(); i++) begin
      if (mc[i] == w) begin
        mc.delete(i);
        mc.push_back(w);
        return 1'b1;
      end
    end
    mc.push_back(w);
    if (mc.size() > 2) void'(mc.pop_front());
    return 1'b0;
  endfunction

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    byt;
    int            lat;   // cycles from issue to rom_ok, -1 = not checked
    int            t0;
  } exp_t;
  exp_t sb[$];

  // SDRAM model controls
  int            ack_w = 0;
  int            rdy_w = 0;
  bit            no_req_chk = 1'b0;
  bit            resp_busy = 1'b0;
  logic [AW-2:0] req_log[$];

  // SDRAM model: ack after ack_w cycles, data rdy_w cycles after the ack
  initial begin
    logic [AW-2:0] cur_a;
    int a, r;
    sdram_ack = 1'b0; data_rdy = 1'b0; sdram_din = 16'h0;
    forever begin
      @(negedge clk);
      if (sdram_req === 1'b1) begin
        resp_busy = 1'b1;
        a = ack_w; r = rdy_w;
        cur_a = sdram_addr;
        req_log.push_back(cur_a);
        for (int k = 0; k < a; k++) begin
          @(negedge clk);
          if (!no_req_chk) begin
            chk("req_held", {31'd0, sdram_req}, 32'd1);
            chk("addr_stable", {17'd0, sdram_addr}, {17'd0, cur_a});
          end
        end
        sdram_ack = 1'b1;
        if (r == 0) begin
          data_rdy = 1'b1; sdram_din = mem[cur_a];
        end
        @(negedge clk);
        sdram_ack = 1'b0; data_rdy = 1'b0; sdram_din = 16'($urandom);
        if (r > 0) begin
          repeat (r - 1) @(negedge clk);
          data_rdy = 1'b1; sdram_din = mem[cur_a];
          @(negedge clk);
          data_rdy = 1'b0; sdram_din = 16'($urandom);
        end
        resp_busy = 1'b0;
      end
    end
  end

  // Monitor: every rom_ok pops one expectation; rom_data must be 0 otherwise
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        if (rom_ok === 1'b1) begin
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL spurious_ok: got rom_ok=1 addr %0h expected no access pending (cycle %0d)",
                     cpu_addr, cyc);
          end else begin
            e = sb.pop_front();
            chk("addr", {16'd0, cpu_addr}, {16'd0, e.addr});
            chk("data", {24'd0, rom_data}, {24'd0, e.byt});
            if (e.lat >= 0) chk("latency", cyc - e.t0, e.lat);
            if (e.lat == 0) chk("hit_no_req", {31'd0, sdram_req}, 32'd0);
          end
        end else begin
          chk("data_zero", {24'd0, rom_data}, 32'd0);
        end
      end
    end
  end

  task automatic wait_ok(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (rom_ok === 1'b1) return;
    end
    n_cmp++; n_err++;
    $display("FAIL timeout: got no rom_ok for addr %0h expected rom_ok within %0d cycles", cpu_addr, bound);
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (!resp_busy) return;
      @(negedge clk);
    end
    n_cmp++; n_err++;
    $display("FAIL sdram_idle: got model busy expected idle within 100 cycles");
  endtask

  task automatic access(input logic [AW-1:0] a, input int aw, input int rw);
    bit h;
    @(posedge clk); #1;
    ack_w = aw; rdy_w = rw;
    cpu_addr = a; rom_cs = 1'b1;
    h = model_access(a[AW-1:1]);
    sb.push_back('{addr: a, byt: exp_byte(a), lat: (h ? 0 : 2 + aw + rw), t0: cyc});
    wait_ok(100);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    rom_cs = 1'b0; cpu_addr = 16'($urandom);
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [AW-2:0] pool [0:5];
    for (int i = 0; i < (1<<(AW-1)); i++) mem[i] = 16'($urandom);
    mem[15'h4000] = 16'hA55A;
    pool = '{15'h1000, 15'h1001, 15'h1002, 15'h1003, 15'h7FFF, 15'h0000};

    rstn = 1'b0; downloading = 1'b0; rom_cs = 1'b0; cpu_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ok", {31'd0, rom_ok}, 32'd0);
    chk("rst_data", {24'd0, rom_data}, 32'd0);
    chk("rst_req", {31'd0, sdram_req}, 32'd0);
    chk("rst_addr", {17'd0, sdram_addr}, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // cold fetch, then neighbouring byte hit
    access(16'h8001, 3, 2);
    chk("cold_addr", {17'd0, req_log[$]}, 32'h4000);
    access(16'h8000, 0, 0);

    // LRU: 0x4001 filled, 0x4000 touched, 0x4002 evicts 0x4001
    access(16'h8002, 1, 1);
    access(16'h8001, 0, 0);
    access(16'h8004, 0, 1);
    access(16'h8000, 0, 0);
    access(16'h8003, 0, 0);

    // same-cycle ack and data
    access(16'h2468, 0, 0);

    // address change mid-request
    n0 = req_log.size();
    @(posedge clk); #1;
    ack_w = 1; rdy_w = 3; cpu_addr = 16'h9000; rom_cs = 1'b1;
    repeat (3) @(posedge clk);
    #1 cpu_addr = 16'h9100;
    void'(model_access(15'h4800));
    void'(model_access(15'h4880));
    sb.push_back('{addr: 16'h9100, byt: exp_byte(16'h9100), lat: -1, t0: cyc});
    wait_ok(100);
    chk("mid_nreq", req_log.size(), n0 + 2);
    if (req_log.size() >= n0 + 2) begin
      chk("mid_first", {17'd0, req_log[n0]}, 32'h4800);
      chk("mid_second", {17'd0, req_log[n0+1]}, 32'h4880);
    end
    access(16'h9000, 0, 0);

    // download during WAIT discards the fill and wipes the cache
    @(posedge clk); #1;
    ack_w = 0; rdy_w = 4; cpu_addr = 16'h3000; rom_cs = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (sdram_ack) break;
    end
    downloading = 1'b1;
    n0 = req_log.size();
    repeat (8) begin
      @(negedge clk);
      chk("dl_ok", {31'd0, rom_ok}, 32'd0);
    end
    @(posedge clk); #1 cpu_addr = 16'h9000;
    @(negedge clk);
    chk("dl_ok_cached", {31'd0, rom_ok}, 32'd0);
    chk("dl_noreq", req_log.size(), n0);
    @(posedge clk); #1 rom_cs = 1'b0; downloading = 1'b0;
    mc.delete();
    wait_idle();
    access(16'h3000, 0, 1);
    access(16'h9000, 0, 0);

    // reset during REQ abandons the request; late ack/data are ignored
    wait_idle();
    @(posedge clk); #1;
    no_req_chk = 1'b1; ack_w = 4; rdy_w = 1; cpu_addr = 16'h5550; rom_cs = 1'b1;
    @(posedge clk); #1;
    rom_cs = 1'b0; rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", {31'd0, sdram_req}, 32'd0);
    mc.delete();
    wait_idle();
    no_req_chk = 1'b0;
    access(16'h5550, 0, 0);
    access(16'h5551, 1, 0);

    // random fetch stream
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      access({pool[$urandom_range(0, 5)], 1'($urandom)},
             $urandom_range(0, 3), $urandom_range(0, 3));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
